fifo_flow_ctrl: RTL and testbench

Flow controller that sequences the team's pointer-addressed FIFO datapath (memory plus occupancy flags). It arbitrates two producers round-robin onto the single write port and generates wr_enable/rd_enable and wr_ptr/rd_ptr. It guards against overflow and underflow, tracks occupancy and flags, and provides a drain sequence for an orderly stop.

---
 rtl/fifo_flow_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_flow_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: write/read sequencing for a pointer-addressed FIFO datapath.
// Two producers share the write port under round-robin arbitration; the
// consumer pops with a one-cycle read latency. A drain request stops new
// pushes, empties the FIFO and parks the controller in HALTED.
module fifo_flow_ctrl #(
  parameter int data_width         = 10,
  parameter int address_width      = 3,
  parameter int almost_full_level  = 7,
  parameter int almost_empty_level = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic [data_width-1:0]    data0,
  input  logic                     req1,
  input  logic [data_width-1:0]    data1,
  output logic                     gnt0,
  output logic                     gnt1,
  input  logic                     pop_req,
  input  logic                     drain,
  output logic                     wr_enable,
  output logic                     rd_enable,
  output logic [address_width-1:0] wr_ptr,
  output logic [address_width-1:0] rd_ptr,
  output logic [data_width-1:0]    fifo_data_in,
  output logic                     pop_valid,
  output logic [address_width:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     err_underflow,
  output logic                     drain_done
);

  localparam logic [address_width:0] depth_c = (address_width+1)'(2**address_width);
  localparam logic [address_width:0] af_c    = (address_width+1)'(almost_full_level);
  localparam logic [address_width:0] ae_c    = (address_width+1)'(almost_empty_level);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last_grant;  // 1: producer 1 was granted last, so producer 0 wins a tie
  logic   push_ok;

  assign full         = (count == depth_c);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_c);
  assign almost_empty = (count <= ae_c);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // next-state: a drain dropped early returns to RUN before it can halt
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain) state_nxt = DRAIN;
      DRAIN:   if (!drain) state_nxt = RUN;
               else if (empty && !pop_valid) state_nxt = HALTED;
      HALTED:  if (!drain) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // outputs: grant gating on current state, round-robin tie break, pop gating
  always_comb begin
    push_ok      = (state == RUN) && !full && !reset;
    gnt0         = push_ok && req0 && (!req1 || last_grant);
    gnt1         = push_ok && req1 && (!req0 || !last_grant);
    wr_enable    = gnt0 | gnt1;
    fifo_data_in = gnt1 ? data1 : data0;
    rd_enable    = pop_req && !empty && (state != HALTED) && !reset;
    drain_done   = (state == HALTED);
  end

  // pointers, occupancy, read-valid pipeline, sticky underflow, arbiter history
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pop_valid     <= 1'b0;
      err_underflow <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      if (wr_enable) wr_ptr <= wr_ptr + address_width'(1);
      if (rd_enable) rd_ptr <= rd_ptr + address_width'(1);
      case ({wr_enable, rd_enable})
        2'b10:   count <= count + (address_width+1)'(1);
        2'b01:   count <= count - (address_width+1)'(1);
        default: count <= count;
      endcase
      pop_valid <= rd_enable;
      if (pop_req && empty) err_underflow <= 1'b1;
      if (gnt0)      last_grant <= 1'b0;
      else if (gnt1) last_grant <= 1'b1;
    end
  end

  // occupancy must stay within 0..depth; a violation is a controller bug
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= depth_c);
      assert (!(wr_enable && !rd_enable && full));
      assert (!(rd_enable && !wr_enable && empty));
    end
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Bench for fifo_flow_ctrl: a small memory stands in for the FIFO datapath,
// expected words are queued when a grant is expected and compared on pop_valid.
module tb_fifo_flow_ctrl;
  localparam int DW = 10;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, req1 = 0, pop_req = 0, drain = 0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, wr_enable, rd_enable, pop_valid;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] fifo_data_in;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, err_underflow, drain_done;

  fifo_flow_ctrl #(.data_width(DW), .address_width(AW), .almost_full_level(7), .almost_empty_level(1)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .pop_req(pop_req), .drain(drain),
    .wr_enable(wr_enable), .rd_enable(rd_enable), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .fifo_data_in(fifo_data_in), .pop_valid(pop_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .err_underflow(err_underflow), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  // FIFO memory model: write at wr_ptr, registered read at rd_ptr
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (wr_enable) mem[wr_ptr] <= fifo_data_in;
    if (rd_enable) rdata <= mem[rd_ptr];
  end

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_w;
  int checks = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic r0, input logic [DW-1:0] d0, input logic r1,
                     input logic [DW-1:0] d1, input logic p, input logic dr);
    req0 = r0; data0 = d0; req1 = r1; data1 = d1; pop_req = p; drain = dr; #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; drv(0, '0, 0, '0, 0, 0); tick(); reset = 1'b0; sb.delete();
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      drv(1, base + DW'(i), 0, '0, 0, 0); sb.push_back(base + DW'(i)); tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; drv(1, 10'h3ff, 1, 10'h155, 1, 0);
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin fails++; $display("FAIL rst_gnt got %b%b exp 00", gnt0, gnt1); end
    checks++; if (rd_enable !== 1'b0) begin fails++; $display("FAIL rst_rden got %b exp 0", rd_enable); end
    tick(); reset = 1'b0; sb.delete(); drv(0, '0, 0, '0, 0, 0);
    checks++; if (count !== 0 || wr_ptr !== 0 || rd_ptr !== 0) begin fails++; $display("FAIL rst_regs got cnt %0d wp %0d rp %0d exp 0", count, wr_ptr, rd_ptr); end
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin fails++; $display("FAIL rst_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); end
    checks++; if ({pop_valid, err_underflow, drain_done, wr_enable} !== 4'b0000) begin fails++; $display("FAIL rst_misc got %b exp 0000", {pop_valid, err_underflow, drain_done, wr_enable}); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = 10'h040 + DW'(i);
      drv(1, d, 0, '0, 0, 0);
      checks++; if (gnt0 !== (i < 8)) begin fails++; $display("FAIL fill_gnt0 c%0d got %b exp %b", i, gnt0, (i < 8)); end
      checks++; if (wr_ptr !== AW'(i)) begin fails++; $display("FAIL fill_wptr c%0d got %0d exp %0d", i, wr_ptr, AW'(i)); end
      checks++; if (count !== (AW+1)'(i)) begin fails++; $display("FAIL fill_count c%0d got %0d exp %0d", i, count, i); end
      checks++; if ({full, almost_full, almost_empty} !== {i == 8, i >= 7, i <= 1}) begin fails++; $display("FAIL fill_flags c%0d got %b exp %b", i, {full, almost_full, almost_empty}, {i == 8, i >= 7, i <= 1}); end
      if (i < 8) begin
        checks++; if (fifo_data_in !== d) begin fails++; $display("FAIL fill_din c%0d got %h exp %h", i, fifo_data_in, d); end
        sb.push_back(d);
      end
      tick();
    end
    for (int j = 0; j < 9; j++) begin
      drv(0, '0, 0, '0, j < 8, 0);
      checks++; if (rd_enable !== (j < 8)) begin fails++; $display("FAIL fill_rden c%0d got %b exp %b", j, rd_enable, (j < 8)); end
      checks++; if (pop_valid !== (j > 0)) begin fails++; $display("FAIL fill_pv c%0d got %b exp %b", j, pop_valid, (j > 0)); end
      if (pop_valid && sb.size() > 0) begin
        exp_w = sb.pop_front();
        checks++; if (rdata !== exp_w) begin fails++; $display("FAIL fill_data c%0d got %h exp %h", j, rdata, exp_w); end
      end
      tick();
    end
    checks++; if (count !== 0 || empty !== 1'b1 || rd_ptr !== 0) begin fails++; $display("FAIL fill_end got cnt %0d empty %b rp %0d exp 0 1 0", count, empty, rd_ptr); end
  endtask

  task automatic test_contention();
    logic e0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1, 10'h100 + DW'(i), 1, 10'h200 + DW'(i), 0, 0);
      e0 = (i % 2 == 0);
      checks++; if ({gnt0, gnt1, wr_enable} !== {e0, !e0, 1'b1}) begin fails++; $display("FAIL cont_gnt c%0d got %b exp %b", i, {gnt0, gnt1, wr_enable}, {e0, !e0, 1'b1}); end
      checks++; if (fifo_data_in !== (e0 ? data0 : data1) || wr_ptr !== AW'(i)) begin fails++; $display("FAIL cont_din c%0d got %h@%0d exp %h@%0d", i, fifo_data_in, wr_ptr, (e0 ? data0 : data1), i); end
      sb.push_back(e0 ? 10'h100 + DW'(i) : 10'h200 + DW'(i));
      tick();
    end
    for (int j = 0; j < 7; j++) begin
      drv(0, '0, 0, '0, j < 6, 0);
      checks++; if (pop_valid !== (j > 0)) begin fails++; $display("FAIL cont_pv c%0d got %b exp %b", j, pop_valid, (j > 0)); end
      if (pop_valid && sb.size() > 0) begin
        exp_w = sb.pop_front();
        checks++; if (rdata !== exp_w) begin fails++; $display("FAIL cont_data c%0d got %h exp %h", j, rdata, exp_w); end
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drv(0, '0, 0, '0, 1, 0);
    checks++; if (rd_enable !== 1'b0) begin fails++; $display("FAIL unf_rden got %b exp 0", rd_enable); end
    tick(); drv(0, '0, 0, '0, 0, 0);
    checks++; if ({pop_valid, err_underflow} !== 2'b01 || rd_ptr !== 0 || count !== 0) begin fails++; $display("FAIL unf_state got pv %b err %b rp %0d cnt %0d exp 0 1 0 0", pop_valid, err_underflow, rd_ptr, count); end
    preload(1, 10'h055);
    drv(0, '0, 0, '0, 1, 0);
    checks++; if (rd_enable !== 1'b1) begin fails++; $display("FAIL unf_rden2 got %b exp 1", rd_enable); end
    tick(); drv(0, '0, 0, '0, 0, 0);
    exp_w = sb.pop_front();
    checks++; if (pop_valid !== 1'b1 || rdata !== exp_w) begin fails++; $display("FAIL unf_pop got pv %b %h exp 1 %h", pop_valid, rdata, exp_w); end
    tick();
    checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL unf_sticky got %b exp 1", err_underflow); end
  endtask

  task automatic test_wrap();
    do_reset();
    preload(3, 10'h010);
    for (int i = 0; i < 10; i++) begin
      drv(1, 10'h020 + DW'(i), 0, '0, 1, 0);
      checks++; if (count !== 3 || {gnt0, rd_enable} !== 2'b11) begin fails++; $display("FAIL wrap_cnt c%0d got cnt %0d g %b rd %b exp 3 1 1", i, count, gnt0, rd_enable); end
      checks++; if (wr_ptr !== AW'(3 + i) || rd_ptr !== AW'(i)) begin fails++; $display("FAIL wrap_ptr c%0d got %0d/%0d exp %0d/%0d", i, wr_ptr, rd_ptr, AW'(3 + i), AW'(i)); end
      checks++; if (pop_valid !== (i > 0)) begin fails++; $display("FAIL wrap_pv c%0d got %b exp %b", i, pop_valid, (i > 0)); end
      sb.push_back(10'h020 + DW'(i));
      if (pop_valid) begin
        exp_w = sb.pop_front();
        checks++; if (rdata !== exp_w) begin fails++; $display("FAIL wrap_data c%0d got %h exp %h", i, rdata, exp_w); end
      end
      tick();
    end
    drv(0, '0, 0, '0, 0, 0);
    exp_w = sb.pop_front();
    checks++; if (pop_valid !== 1'b1 || rdata !== exp_w || count !== 3) begin fails++; $display("FAIL wrap_tail got pv %b %h cnt %0d exp 1 %h 3", pop_valid, rdata, count, exp_w); end
  endtask

  task automatic test_drain();
    do_reset();
    preload(3, 10'h030);
    drv(1, 10'h03a, 0, '0, 1, 1);
    checks++; if ({gnt0, rd_enable, drain_done} !== 3'b110) begin fails++; $display("FAIL drn_entry got %b exp 110", {gnt0, rd_enable, drain_done}); end
    sb.push_back(10'h03a);
    tick();
    for (int d = 0; d < 6; d++) begin
      drv(1, 10'h0f0 + DW'(d), 0, '0, d < 3, 1);
      checks++; if ({gnt0, wr_enable} !== 2'b00) begin fails++; $display("FAIL drn_nognt c%0d got %b exp 00", d, {gnt0, wr_enable}); end
      checks++; if (pop_valid !== (d <= 3)) begin fails++; $display("FAIL drn_pv c%0d got %b exp %b", d, pop_valid, (d <= 3)); end
      if (d < 3) begin
        checks++; if (rd_enable !== 1'b1 || count !== (AW+1)'(3 - d)) begin fails++; $display("FAIL drn_pop c%0d got rd %b cnt %0d exp 1 %0d", d, rd_enable, count, 3 - d); end
      end
      if (pop_valid && sb.size() > 0) begin
        exp_w = sb.pop_front();
        checks++; if (rdata !== exp_w) begin fails++; $display("FAIL drn_data c%0d got %h exp %h", d, rdata, exp_w); end
      end
      if (d == 3) begin
        checks++; if (drain_done !== 1'b0) begin fails++; $display("FAIL drn_early got %b exp 0", drain_done); end
      end
      if (d == 5) begin
        checks++; if (drain_done !== 1'b1 || empty !== 1'b1) begin fails++; $display("FAIL drn_halt got dd %b empty %b exp 1 1", drain_done, empty); end
      end
      tick();
    end
    drv(1, 10'h03f, 0, '0, 0, 0);
    checks++; if ({drain_done, gnt0} !== 2'b10) begin fails++; $display("FAIL drn_release got %b exp 10", {drain_done, gnt0}); end
    tick(); drv(1, 10'h03f, 0, '0, 0, 0);
    checks++; if ({drain_done, gnt0} !== 2'b01) begin fails++; $display("FAIL drn_resume got %b exp 01", {drain_done, gnt0}); end
    tick();
    checks++; if (count !== 1) begin fails++; $display("FAIL drn_count got %0d exp 1", count); end
  endtask

  task automatic test_drain_abort();
    do_reset();
    preload(2, 10'h060);
    drv(0, '0, 0, '0, 0, 1); tick();
    drv(1, 10'h062, 0, '0, 0, 0);
    checks++; if ({gnt0, drain_done} !== 2'b00) begin fails++; $display("FAIL abort_drain got %b exp 00", {gnt0, drain_done}); end
    tick(); drv(1, 10'h063, 0, '0, 0, 0);
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL abort_run got %b exp 1", gnt0); end
    tick();
    checks++; if (count !== 3) begin fails++; $display("FAIL abort_count got %0d exp 3", count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drv(0, '0, 0, '0, 1, 0); tick();
    preload(5, 10'h070);
    drv(0, '0, 0, '0, 1, 0);
    checks++; if (rd_enable !== 1'b1 || err_underflow !== 1'b1) begin fails++; $display("FAIL mrst_pre got rd %b err %b exp 1 1", rd_enable, err_underflow); end
    tick();
    reset = 1'b1; drv(1, 10'h07f, 0, '0, 1, 0);
    checks++; if ({gnt0, rd_enable} !== 2'b00) begin fails++; $display("FAIL mrst_gate got %b exp 00", {gnt0, rd_enable}); end
    tick(); reset = 1'b0; sb.delete(); drv(0, '0, 0, '0, 0, 0);
    checks++; if (count !== 0 || empty !== 1'b1 || wr_ptr !== 0 || rd_ptr !== 0) begin fails++; $display("FAIL mrst_regs got cnt %0d e %b wp %0d rp %0d exp 0 1 0 0", count, empty, wr_ptr, rd_ptr); end
    checks++; if ({pop_valid, err_underflow, drain_done} !== 3'b000) begin fails++; $display("FAIL mrst_misc got %b exp 000", {pop_valid, err_underflow, drain_done}); end
    drv(1, 10'h077, 0, '0, 0, 0);
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL mrst_run got %b exp 1", gnt0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_contention();
    test_underflow();
    test_wrap();
    test_drain();
    test_drain_abort();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
